// File: rtl/adder_wide_seq.sv
// adder_wide_seq: W = N*K bit adder built from one N-bit ripple slice reused over K cycles, LSB slice first.
// Latency: out_valid rises K cycles after the accepting edge; one operation per K+2 cycles with out_ready high.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready, and no new operands are taken meanwhile.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, c_in; out_valid/out_ready with sum, c_out (registered).

// adder_nbit_st: combinational N-bit ripple-carry slice.
// Latency: none (pure combinational).
// Backpressure: none; the caller owns the handshake.
module adder_nbit_st #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] w_carry;

  assign w_carry[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = w_carry[N];

endmodule

module adder_wide_seq #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K-1:0]   a,
  input  logic [N*K-1:0]   b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   sum,
  output logic             c_out
);

  localparam int W  = N * K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_psum;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_sum;
  logic            r_cout;

  logic [N-1:0]    w_slice_sum;
  logic            w_slice_cout;
  logic [W-1:0]    w_psum_nxt;
  logic            w_last;

  // Only the low slice of each operand register is ever added; the
  // registers shift right so the next slice lands in the low bits.
  adder_nbit_st #(.N(N)) u_slice (
    .a     (r_a[N-1:0]),
    .b     (r_b[N-1:0]),
    .c_in  (r_carry),
    .sum   (w_slice_sum),
    .c_out (w_slice_cout)
  );

  // New slice enters at the top; after K shifts the first slice sits at bit 0.
  if (K == 1) begin : g_psum_single
    assign w_psum_nxt = w_slice_sum;
  end else begin : g_psum_multi
    assign w_psum_nxt = {w_slice_sum, r_psum[W-1:N]};
  end

  assign w_last    = (r_cnt == CW'(K - 1));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign c_out     = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> N;
          r_b     <= r_b >> N;
          r_psum  <= w_psum_nxt;
          r_carry <= w_slice_cout;
          r_cnt   <= r_cnt + CW'(1);
          // Result registers update only here, so they keep the last
          // sum through DONE and after returning to IDLE.
          if (w_last) begin
            r_sum  <= w_psum_nxt;
            r_cout <= w_slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_wide_seq.sv
// tb_adder_wide_seq: scoreboard bench for adder_wide_seq at (N=4,K=4), (N=8,K=1) and (N=4,K=3).
// Latency: checks out_valid arrives exactly K cycles after acceptance on the 16-bit instance.
// Backpressure: holds out_ready low on directed runs and randomises it on the regression runs.
module tb_adder_wide_seq;

  localparam int NOPS = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- instance 0: N=4, K=4, W=16 ----------------
  logic        in_valid0 = 0, in_ready0, out_valid0, out_ready0 = 1, c_in0 = 0, c_out0;
  logic [15:0] a0 = 0, b0 = 0, sum0;
  logic [16:0] q0[$];

  adder_wide_seq #(.N(4), .K(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .c_in(c_in0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .c_out(c_out0)
  );

  // ---------------- instance 1: N=8, K=1, W=8 ----------------
  logic        in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 1, c_in1 = 0, c_out1;
  logic [7:0]  a1 = 0, b1 = 0, sum1;
  logic [16:0] q1[$];
  int          rcv1 = 0;

  adder_wide_seq #(.N(8), .K(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .c_out(c_out1)
  );

  // ---------------- instance 3: N=4, K=3, W=12 ----------------
  logic        in_valid3 = 0, in_ready3, out_valid3, out_ready3 = 1, c_in3 = 0, c_out3;
  logic [11:0] a3 = 0, b3 = 0, sum3;
  logic [16:0] q3[$];
  int          rcv3 = 0;

  adder_wide_seq #(.N(4), .K(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .c_in(c_in3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sum(sum3), .c_out(c_out3)
  );

  // Output monitors: a transfer happens on the edge after a negedge
  // where out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready0) begin
      if (q0.size() == 0) chk("dut0_unexpected_out", 64'(out_valid0), 64'd0);
      else chk("dut0_result", 64'({c_out0, sum0}), 64'(q0.pop_front()));
    end
    if (rst_n && out_valid1 && out_ready1) begin
      rcv1++;
      if (q1.size() == 0) chk("dut1_unexpected_out", 64'(out_valid1), 64'd0);
      else chk("dut1_result", 64'({c_out1, sum1}), 64'(q1.pop_front()));
    end
    if (rst_n && out_valid3 && out_ready3) begin
      rcv3++;
      if (q3.size() == 0) chk("dut3_unexpected_out", 64'(out_valid3), 64'd0);
      else chk("dut3_result", 64'({c_out3, sum3}), 64'(q3.pop_front()));
    end
  end

  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + 17'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on instance 0 and verify exact K=4 latency.
  task automatic op0(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready0), 64'd1);
    in_valid0 = 1; a0 = a; b0 = b; c_in0 = c;
    q0.push_back(ref16(a, b, c));
    tick();
    in_valid0 = 0; a0 = 16'hDEAD; b0 = 16'hBEEF; c_in0 = 1;
    repeat (3) tick();
    chk({tag, "_valid_early"}, 64'(out_valid0), 64'd0);
    tick();
    chk({tag, "_valid_at_k"}, 64'(out_valid0), 64'd1);
  endtask

  task automatic prod1();
    for (int i = 0; i < NOPS; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      int         guard;
      repeat ($urandom_range(0, 2)) tick();
      guard = 0;
      while (!in_ready1 && guard < 200) begin tick(); guard++; end
      if (guard >= 200) begin chk("dut1_in_timeout", 64'(in_ready1), 64'd1); break; end
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      in_valid1 = 1; a1 = ra; b1 = rb; c_in1 = rc;
      q1.push_back(17'({1'b0, ra} + {1'b0, rb} + 9'(rc)));
      tick();
      in_valid1 = 0; a1 = 8'($urandom); b1 = 8'($urandom);
    end
  endtask

  task automatic prod3();
    for (int i = 0; i < NOPS; i++) begin
      logic [11:0] ra, rb;
      logic        rc;
      int          guard;
      repeat ($urandom_range(0, 2)) tick();
      guard = 0;
      while (!in_ready3 && guard < 200) begin tick(); guard++; end
      if (guard >= 200) begin chk("dut3_in_timeout", 64'(in_ready3), 64'd1); break; end
      ra = 12'($urandom); rb = 12'($urandom); rc = 1'($urandom);
      in_valid3 = 1; a3 = ra; b3 = rb; c_in3 = rc;
      q3.push_back(17'({1'b0, ra} + {1'b0, rb} + 13'(rc)));
      tick();
      in_valid3 = 0; a3 = 12'($urandom); b3 = 12'($urandom);
    end
  endtask

  task automatic cons1();
    int cyc = 0;
    while (rcv1 < NOPS && cyc < 30000) begin
      out_ready1 = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    out_ready1 = 1;
    chk("dut1_received", 64'(rcv1), 64'(NOPS));
  endtask

  task automatic cons3();
    int cyc = 0;
    while (rcv3 < NOPS && cyc < 40000) begin
      out_ready3 = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    out_ready3 = 1;
    chk("dut3_received", 64'(rcv3), 64'(NOPS));
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_in_ready", 64'(in_ready0), 64'd1);
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_sum_cout", 64'({c_out0, sum0}), 64'd0);
    rst_n = 1;
    tick();

    // Carry across every slice boundary, then two plain additions
    op0(16'hFFFF, 16'h0001, 1'b0, "carry_chain");
    tick();
    chk("back_to_idle", 64'(in_ready0), 64'd1);
    op0(16'h1234, 16'h4321, 1'b1, "cin_add");
    tick();
    op0(16'h8000, 16'h8000, 1'b0, "msb_overflow");
    tick();

    // Backpressure: result must hold for 10 cycles
    out_ready0 = 0;
    op0(16'hABCD, 16'h1111, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_hold", 64'(out_valid0), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready0), 64'd0);
      chk("bp_sum_hold", 64'({c_out0, sum0}), 64'h0BCDE);
      tick();
    end
    out_ready0 = 1;
    tick();
    chk("bp_release_idle", 64'(in_ready0), 64'd1);
    chk("bp_release_valid", 64'(out_valid0), 64'd0);
    chk("bp_sum_kept", 64'({c_out0, sum0}), 64'h0BCDE);

    // Busy input: in_valid held with other operands through RUN and DONE
    out_ready0 = 0;
    chk("busy_in_ready", 64'(in_ready0), 64'd1);
    in_valid0 = 1; a0 = 16'h0F0F; b0 = 16'h00F1; c_in0 = 1;
    q0.push_back(ref16(16'h0F0F, 16'h00F1, 1'b1));
    tick();
    a0 = 16'hFFFF; b0 = 16'hFFFF; c_in0 = 1;
    repeat (4) tick();
    chk("busy_done", 64'(out_valid0), 64'd1);
    tick();
    chk("busy_ignored_in_done", 64'(in_ready0), 64'd0);
    in_valid0 = 0;
    out_ready0 = 1;
    tick();
    chk("busy_idle", 64'(in_ready0), 64'd1);

    // Reset while RUN counter == 2: no clock edge needed to clear
    in_valid0 = 1; a0 = 16'h5555; b0 = 16'h2222; c_in0 = 0;
    tick();
    in_valid0 = 0;
    repeat (2) tick();
    rst_n = 0;
    #1;
    chk("midrun_rst_in_ready", 64'(in_ready0), 64'd1);
    chk("midrun_rst_out_valid", 64'(out_valid0), 64'd0);
    chk("midrun_rst_sum_cout", 64'({c_out0, sum0}), 64'd0);
    #1;
    rst_n = 1;
    tick();
    op0(16'h7FFF, 16'h0001, 1'b0, "after_rst");
    tick();
    chk("q0_drained", 64'(q0.size()), 64'd0);

    // Random regressions on the K=1 and K=3 instances
    fork
      prod1();
      cons1();
      prod3();
      cons3();
    join
    repeat (4) tick();
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q3_drained", 64'(q3.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
